bist_response_analyzer: RTL

Output-response analyzer for the BIST datapath: the receiving end of the test-pattern path. It consumes the circuit-under-test responses produced during test mode, compresses a fixed number of them into a multiple-input signature register (MISR), and compares the final signature against a golden value. The result is reported as `done` / `fault_detected` to the top-level BIST wrapper and the testbench.

---
 rtl/bist_response_analyzer.sv | 102 ++++++++++
 1 files changed

// File: rtl/bist_response_analyzer.sv
// BIST output-response analyzer: compresses PATTERNS CUT responses into a
// Galois MISR and flags a fault when the final signature differs from GOLDEN.
module bist_response_analyzer #(
    parameter int                 WIDTH    = 4,
    parameter int                 PATTERNS = 15,
    parameter logic [WIDTH-1:0]   POLY     = 4'h3,
    parameter logic [WIDTH-1:0]   SEED     = 4'h0,
    parameter logic [WIDTH-1:0]   GOLDEN   = 4'h0,
    localparam int                CNT_W    = $clog2(PATTERNS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic             fault_detected,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] resp_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMPRESS = 2'd1,
        COMPARE  = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PATTERNS - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] misr_q;
    logic [CNT_W-1:0] count_q;
    logic             done_q;
    logic             fault_q;
    logic             run_start;
    logic             accept;

    // One Galois shift (multiply by x modulo the feedback polynomial) folded with the response word.
    function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] din);
        misr_step = {cur[WIDTH-2:0], 1'b0} ^ (cur[WIDTH-1] ? POLY : '0) ^ din;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run_start = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    run_start = 1'b1;
                    state_nxt = COMPRESS;
                end
            end
            COMPRESS: begin
                if (resp_valid) begin
                    accept = 1'b1;
                    if (count_q == LAST_CNT) state_nxt = COMPARE;
                end
            end
            COMPARE: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misr_q  <= SEED;
            count_q <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else if (run_start) begin
            misr_q  <= SEED;
            count_q <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else if (accept) begin
            misr_q  <= misr_step(misr_q, resp);
            count_q <= count_q + CNT_W'(1);
        end else if (state == COMPARE) begin
            fault_q <= (misr_q != GOLDEN);
            done_q  <= 1'b1;
        end
    end

    assign busy           = (state == COMPRESS) || (state == COMPARE);
    assign done           = done_q;
    assign fault_detected = fault_q;
    assign signature      = misr_q;
    assign resp_count     = count_q;

endmodule
